// File: rtl/hex_keypad_entry_if.sv
// Keypad entry bus: raw rows and clear in; column drive, keystroke events and operand out.
// The master side drives the rows (the keypad) and the clear; the slave side is the scanner.
interface hex_keypad_entry_if;
   logic [3:0]  row;
   logic        clr;
   logic [3:0]  col;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        key_held;
   logic [31:0] value;

   modport master (
      output row, clr,
      input  col, key_valid, key_code, key_held, value
   );

   modport slave (
      input  row, clr,
      output col, key_valid, key_code, key_held, value
   );
endinterface

// File: rtl/hex_keypad_entry.sv
// 4x4 hex keypad scanner with press/release debounce and a 32-bit digit-entry operand.
// Optional auto-repeat while a key stays down: define KEYPAD_AUTOREPEAT_EN.
module hex_keypad_entry #(
   parameter logic [15:0] SCAN_DIV     = 16'd1000,
   parameter logic [19:0] DEBOUNCE_CNT = 20'd50000,
   parameter logic [23:0] REPEAT_CNT   = 24'd5000000
) (
   input  logic clk,
   input  logic rst_n,
   hex_keypad_entry_if.slave kp
);

   typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} state_t;

   localparam logic [19:0] SCAN_LAST = {4'd0, SCAN_DIV - 16'd1};
   localparam logic [19:0] DEB_LAST  = DEBOUNCE_CNT - 20'd1;
`ifdef KEYPAD_AUTOREPEAT_EN
   localparam logic [23:0] REP_LAST  = REPEAT_CNT - 24'd1;
`endif

   state_t      state;
   logic [19:0] cnt;
   logic [3:0]  row_p0;
   logic [3:0]  row_s;
   logic [3:0]  col;
   logic [1:0]  row_idx;
   logic [1:0]  col_idx;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        key_held;
   logic [31:0] value;
   logic [3:0]  code;
`ifdef KEYPAD_AUTOREPEAT_EN
   logic [23:0] rep_cnt;
`endif

   function automatic logic [3:0] rotl(input logic [3:0] c);
      return {c[2:0], c[3]};
   endfunction

   // Lowest-numbered low row wins when several keys in one column are down.
   function automatic logic [1:0] lowest_row(input logic [3:0] r);
      if (!r[0])      return 2'd0;
      else if (!r[1]) return 2'd1;
      else if (!r[2]) return 2'd2;
      else            return 2'd3;
   endfunction

   function automatic logic [1:0] col_index(input logic [3:0] c);
      case (c)
         4'b1101: return 2'd1;
         4'b1011: return 2'd2;
         4'b0111: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   assign code = {row_idx, col_idx};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= SCAN;
         cnt       <= '0;
         row_p0    <= 4'hF;
         row_s     <= 4'hF;
         col       <= 4'b1110;
         row_idx   <= '0;
         col_idx   <= '0;
         key_valid <= 1'b0;
         key_code  <= '0;
         key_held  <= 1'b0;
         value     <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
         rep_cnt   <= '0;
`endif
      end else begin
         // synchronizer stage: rows are asynchronous to clk
         row_p0    <= kp.row;
         row_s     <= row_p0;
         key_valid <= 1'b0;

         case (state)
            SCAN: begin
               if (cnt == SCAN_LAST) begin
                  cnt <= '0;
                  if (row_s == 4'hF) begin
                     col <= rotl(col);
                  end else begin
                     row_idx <= lowest_row(row_s);
                     col_idx <= col_index(col);
                     state   <= PRESS_DB;
                  end
               end else begin
                  cnt <= cnt + 20'd1;
               end
            end

            PRESS_DB: begin
               if (row_s[row_idx]) begin
                  cnt   <= '0;
                  col   <= rotl(col);
                  state <= SCAN;
               end else if (cnt == DEB_LAST) begin
                  cnt       <= '0;
                  key_valid <= 1'b1;
                  key_code  <= code;
                  value     <= {value[27:0], code};
                  key_held  <= 1'b1;
                  state     <= HELD;
               end else begin
                  cnt <= cnt + 20'd1;
               end
            end

            HELD: begin
`ifdef KEYPAD_AUTOREPEAT_EN
               if (row_s[row_idx]) begin
                  cnt     <= '0;
                  rep_cnt <= '0;
                  state   <= REL_DB;
               end else if (rep_cnt == REP_LAST) begin
                  rep_cnt   <= '0;
                  key_valid <= 1'b1;
                  value     <= {value[27:0], key_code};
               end else begin
                  rep_cnt <= rep_cnt + 24'd1;
               end
`else
               if (row_s[row_idx]) begin
                  cnt   <= '0;
                  state <= REL_DB;
               end
`endif
            end

            REL_DB: begin
               if (!row_s[row_idx]) begin
                  cnt   <= '0;
                  state <= HELD;
               end else if (cnt == DEB_LAST) begin
                  cnt      <= '0;
                  key_held <= 1'b0;
                  col      <= rotl(col);
                  state    <= SCAN;
               end else begin
                  cnt <= cnt + 20'd1;
               end
            end

            default: state <= SCAN;
         endcase

         // clear has the last word over any shift in the same cycle
         if (kp.clr) value <= '0;
      end
   end

   assign kp.col       = col;
   assign kp.key_valid = key_valid;
   assign kp.key_code  = key_code;
   assign kp.key_held  = key_held;
   assign kp.value     = value;

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Bench for hex_keypad_entry: a key-matrix model turns pressed keys plus column drive into rows.
module tb_hex_keypad_entry;

   logic        clk;
   logic        rst_n;
   logic [15:0] keys;
   int          total;
   int          bad;
   int          kv_cnt;

   hex_keypad_entry_if kif ();

   hex_keypad_entry #(
      .SCAN_DIV     (16'd4),
      .DEBOUNCE_CNT (20'd8),
      .REPEAT_CNT   (24'd32)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .kp    (kif)
   );

   // key index = row*4 + col; a row reads low when a pressed key sits on a driven column
   function automatic logic [3:0] matrix_rows(input logic [3:0] c, input logic [15:0] k);
      logic [3:0] r;
      r = 4'hF;
      for (int ri = 0; ri < 4; ri++)
         for (int ci = 0; ci < 4; ci++)
            if (k[ri*4+ci] && !c[ci]) r[ri] = 1'b0;
      return r;
   endfunction

   assign kif.row = matrix_rows(kif.col, keys);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial kv_cnt = 0;
   always @(negedge clk) if (kif.key_valid === 1'b1) kv_cnt <= kv_cnt + 1;

   task automatic wait_col(input logic [3:0] target, output bit ok);
      logic [3:0] prev;
      prev = kif.col;
      ok   = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (kif.col == target && prev != target) begin
            ok = 1'b1;
            break;
         end
         prev = kif.col;
      end
   endtask

   task automatic do_press(input logic [3:0] code);
      keys       = '0;
      keys[code] = 1'b1;
      repeat (40) @(negedge clk);
      keys = '0;
      repeat (16) @(negedge clk);
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      kif.clr = 1'b1;
      @(negedge clk);
      kif.clr = 1'b0;
   endtask

   task automatic test_reset();
      logic [3:0] col_seq [4];
      col_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({kif.col, kif.key_valid, kif.key_code, kif.key_held} !== {4'b1110, 1'b0, 4'h0, 1'b0}) begin
         bad++;
         $display("FAIL reset_outputs: got col=%b kv=%b code=%h held=%b want 1110 0 0 0",
                  kif.col, kif.key_valid, kif.key_code, kif.key_held);
      end
      total++;
      if (kif.value !== 32'h0) begin
         bad++;
         $display("FAIL reset_value: got %h want 00000000", kif.value);
      end
      rst_n = 1'b1;
      for (int k = 0; k <= 16; k++) begin
         if (k > 0) @(negedge clk);
         total++;
         if (kif.col !== col_seq[(k/4)%4]) begin
            bad++;
            $display("FAIL scan_col_%0d: got %b want %b", k, kif.col, col_seq[(k/4)%4]);
         end
      end
      total++;
      if (kv_cnt !== 0 || kif.value !== 32'h0) begin
         bad++;
         $display("FAIL idle_no_key: got pulses=%0d value=%h want 0 0", kv_cnt, kif.value);
      end
   endtask

   task automatic test_single_press();
      int start;
      start = kv_cnt;
      keys = '0;
      keys[6] = 1'b1;
      repeat (40) @(negedge clk);
      total++;
      if (kif.key_held !== 1'b1) begin
         bad++;
         $display("FAIL held_while_down: got %b want 1", kif.key_held);
      end
      keys = '0;
      repeat (16) @(negedge clk);
      total++;
      if (kif.key_held !== 1'b0) begin
         bad++;
         $display("FAIL held_after_release: got %b want 0", kif.key_held);
      end
      total++;
      if (kv_cnt - start !== 1) begin
         bad++;
         $display("FAIL single_pulses: got %0d want 1", kv_cnt - start);
      end
      total++;
      if (kif.key_code !== 4'h6 || kif.value !== 32'h6) begin
         bad++;
         $display("FAIL single_code_value: got code=%h value=%h want 6 00000006", kif.key_code, kif.value);
      end
   endtask

   task automatic test_digit_entry();
      int start;
      pulse_clr();
      start = kv_cnt;
      for (int d = 1; d <= 9; d++) do_press(4'(d));
      total++;
      if (kif.value !== 32'h23456789) begin
         bad++;
         $display("FAIL nine_digits_value: got %h want 23456789", kif.value);
      end
      total++;
      if (kv_cnt - start !== 9) begin
         bad++;
         $display("FAIL nine_digits_pulses: got %0d want 9", kv_cnt - start);
      end
   endtask

   task automatic test_bounce();
      int start;
      bit ok;
      pulse_clr();
      start = kv_cnt;
      wait_col(4'b1011, ok);
      keys = '0;
      keys[6] = 1'b1;
      repeat (5) @(negedge clk);
      keys = '0;
      repeat (20) @(negedge clk);
      total++;
      if (kv_cnt - start !== 0 || kif.value !== 32'h0) begin
         bad++;
         $display("FAIL press_bounce: got pulses=%0d value=%h sync=%b want 0 0", kv_cnt - start, kif.value, ok);
      end
      wait_col(4'b1110, ok);
      total++;
      if (ok !== 1'b1) begin
         bad++;
         $display("FAIL scan_resume: got timeout want column 1110 reached");
      end
      start = kv_cnt;
      keys[6] = 1'b1;
      repeat (40) @(negedge clk);
      keys = '0;
      repeat (3) @(negedge clk);
      keys[6] = 1'b1;
      repeat (10) @(negedge clk);
      total++;
      if (kif.key_held !== 1'b1) begin
         bad++;
         $display("FAIL held_through_bounce: got %b want 1", kif.key_held);
      end
      keys = '0;
      repeat (16) @(negedge clk);
      total++;
      if (kv_cnt - start !== 1 || kif.value !== 32'h6 || kif.key_held !== 1'b0) begin
         bad++;
         $display("FAIL release_bounce: got pulses=%0d value=%h held=%b want 1 00000006 0",
                  kv_cnt - start, kif.value, kif.key_held);
      end
   endtask

   task automatic test_priority_clr();
      bit ok;
      wait_col(4'b0111, ok);
      keys = '0;
      keys[3]  = 1'b1;
      keys[11] = 1'b1;
      repeat (11) @(negedge clk);
      kif.clr = 1'b1;
      @(negedge clk);
      total++;
      if (kif.key_valid !== 1'b1 || kif.key_code !== 4'h3) begin
         bad++;
         $display("FAIL multi_key_event: got kv=%b code=%h sync=%b want 1 3", kif.key_valid, kif.key_code, ok);
      end
      total++;
      if (kif.value !== 32'h0) begin
         bad++;
         $display("FAIL clr_over_shift: got %h want 00000000", kif.value);
      end
      kif.clr = 1'b0;
      repeat (20) @(negedge clk);
      keys = '0;
      repeat (16) @(negedge clk);
      total++;
      if (kif.value !== 32'h0 || kif.key_code !== 4'h3) begin
         bad++;
         $display("FAIL after_clr: got value=%h code=%h want 00000000 3", kif.value, kif.key_code);
      end
   endtask

   task automatic test_reset_mid_press();
      bit ok;
      bit seen;
      do_press(4'h5);
      total++;
      if (kif.value !== 32'h5 || kif.key_code !== 4'h5) begin
         bad++;
         $display("FAIL pre_reset_key: got value=%h code=%h want 00000005 5", kif.value, kif.key_code);
      end
      wait_col(4'b1011, ok);
      keys = '0;
      keys[10] = 1'b1;
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++;
      if ({kif.col, kif.key_valid, kif.key_code, kif.key_held} !== {4'b1110, 1'b0, 4'h0, 1'b0} ||
          kif.value !== 32'h0) begin
         bad++;
         $display("FAIL async_reset: got col=%b kv=%b code=%h held=%b value=%h want 1110 0 0 0 0",
                  kif.col, kif.key_valid, kif.key_code, kif.key_held, kif.value);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (kif.key_valid === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      total++;
      if (seen !== 1'b1 || kif.key_code !== 4'hA || kif.value !== 32'hA) begin
         bad++;
         $display("FAIL redetect_after_reset: got seen=%b code=%h value=%h want 1 a 0000000a",
                  seen, kif.key_code, kif.value);
      end
      keys = '0;
      repeat (16) @(negedge clk);
   endtask

   task automatic test_long_hold();
      int start;
      bit ok;
      pulse_clr();
      wait_col(4'b0111, ok);
      start = kv_cnt;
      keys = '0;
      keys[3] = 1'b1;
      repeat (100) @(negedge clk);
      keys = '0;
      repeat (16) @(negedge clk);
`ifdef KEYPAD_AUTOREPEAT_EN
      total++;
      if (kv_cnt - start !== 3 || kif.value !== 32'h333) begin
         bad++;
         $display("FAIL autorepeat: got pulses=%0d value=%h want 3 00000333", kv_cnt - start, kif.value);
      end
`else
      total++;
      if (kv_cnt - start !== 1 || kif.value !== 32'h3) begin
         bad++;
         $display("FAIL no_repeat: got pulses=%0d value=%h want 1 00000003", kv_cnt - start, kif.value);
      end
`endif
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      keys    = '0;
      kif.clr = 1'b0;
      rst_n   = 1'b0;
      test_reset();
      test_single_press();
      test_digit_entry();
      test_bounce();
      test_priority_clr();
      test_reset_mid_press();
      test_long_hold();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
